mem1_lsu: RTL and testbench

MEM1_LSU -- requirements
Module: mem1_lsu

---
 rtl/mem1_lsu.sv | 158 +++++++++++++++
 tb/tb_mem1_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem1_lsu.sv
// M1 load/store unit: issues data-memory requests, stalls the pipeline while
// waiting for dmem_ack with a timeout abort, and feeds the M2 pipeline register.
module mem1_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_m1,
    input  logic [1:0]  result_src_m1,
    input  logic        mem_write_m1,
    input  logic [31:0] alu_result_m1,
    input  logic [31:0] write_data_m1,
    input  logic [2:0]  funct3_m1,
    input  logic [4:0]  rd_m1,
    input  logic [31:0] pc_plus4_m1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m1,
    output logic        reg_write_m2,
    output logic [1:0]  result_src_m2,
    output logic [31:0] alu_result_m2,
    output logic [31:0] read_data_m2,
    output logic [4:0]  rd_m2,
    output logic [31:0] pc_plus4_m2,
    output logic        misalign_m2,
    output logic        bus_err_m2
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_is_load, w_access, w_aligned, w_req;
    logic            w_timeout_hit, w_stall, w_bus_err, w_misalign, w_complete;

    function automatic logic [3:0] f_store_be(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'b00:   f_store_be = 4'b0001 << off;
            2'b01:   f_store_be = 4'b0011 << off;
            default: f_store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [31:0] data, input logic [1:0] size);
        case (size)
            2'b00:   f_store_data = {4{data[7:0]}};
            2'b01:   f_store_data = {2{data[15:0]}};
            default: f_store_data = data;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [31:0] word, input logic [1:0] off,
                                                   input logic [2:0] f3);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'b000:  f_load_extract = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  f_load_extract = {24'h000000, shifted[7:0]};
            3'b001:  f_load_extract = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  f_load_extract = {16'h0000, shifted[15:0]};
            default: f_load_extract = word;
        endcase
    endfunction

    // Access decode, alignment and request/stall generation
    always_comb begin
        w_is_load = (result_src_m1 == 2'b01);
        w_access  = mem_write_m1 | w_is_load;
        case (funct3_m1[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~alu_result_m1[0];
            default: w_aligned = (alu_result_m1[1:0] == 2'b00);
        endcase
        // reset also kills the request so an aborted access is never reissued while in reset
        w_req         = w_access & w_aligned & ~rst;
        w_timeout_hit = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));
        w_stall       = w_req & ~dmem_ack & ~w_timeout_hit;
        w_bus_err     = w_req & w_timeout_hit & ~dmem_ack;
        w_misalign    = w_access & ~w_aligned;
        w_complete    = w_is_load & w_req & dmem_ack;
    end

    assign dmem_req   = w_req;
    assign dmem_we    = mem_write_m1;
    assign dmem_addr  = {alu_result_m1[31:2], 2'b00};
    assign dmem_be    = f_store_be(alu_result_m1[1:0], funct3_m1[1:0]);
    assign dmem_wdata = f_store_data(write_data_m1, funct3_m1[1:0]);
    assign stall_m1   = w_stall;

    // Next state; the counter holds cycles already spent waiting, issue cycle included
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req & ~dmem_ack) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (~w_req | dmem_ack | w_timeout_hit) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // M2 pipeline register: bubble while stalled
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            reg_write_m2  <= 1'b0;
            result_src_m2 <= 2'b00;
            alu_result_m2 <= 32'h0000_0000;
            read_data_m2  <= 32'h0000_0000;
            rd_m2         <= 5'd0;
            pc_plus4_m2   <= 32'h0000_0000;
            misalign_m2   <= 1'b0;
            bus_err_m2    <= 1'b0;
        end else begin
            reg_write_m2  <= reg_write_m1 & ~w_misalign & ~w_bus_err;
            result_src_m2 <= result_src_m1;
            alu_result_m2 <= alu_result_m1;
            read_data_m2  <= w_complete ? f_load_extract(dmem_rdata, alu_result_m1[1:0], funct3_m1)
                                        : 32'h0000_0000;
            rd_m2         <= rd_m1;
            pc_plus4_m2   <= pc_plus4_m1;
            misalign_m2   <= w_misalign;
            bus_err_m2    <= w_bus_err;
        end
    end
endmodule

// File: tb/tb_mem1_lsu.sv
// Self-checking bench for mem1_lsu: reference model compared every cycle plus
// directed vectors with hand-computed expectations.
module tb_mem1_lsu;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write_m1, mem_write_m1, dmem_ack;
    logic [1:0]  result_src_m1;
    logic [31:0] alu_result_m1, write_data_m1, pc_plus4_m1, dmem_rdata;
    logic [2:0]  funct3_m1;
    logic [4:0]  rd_m1;
    logic        dmem_req, dmem_we, stall_m1, reg_write_m2, misalign_m2, bus_err_m2;
    logic [31:0] dmem_addr, dmem_wdata, alu_result_m2, read_data_m2, pc_plus4_m2;
    logic [3:0]  dmem_be;
    logic [1:0]  result_src_m2;
    logic [4:0]  rd_m2;

    always #5 clk = ~clk;

    mem1_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .reg_write_m1(reg_write_m1), .result_src_m1(result_src_m1),
        .mem_write_m1(mem_write_m1), .alu_result_m1(alu_result_m1), .write_data_m1(write_data_m1),
        .funct3_m1(funct3_m1), .rd_m1(rd_m1), .pc_plus4_m1(pc_plus4_m1),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_m1(stall_m1),
        .reg_write_m2(reg_write_m2), .result_src_m2(result_src_m2), .alu_result_m2(alu_result_m2),
        .read_data_m2(read_data_m2), .rd_m2(rd_m2), .pc_plus4_m2(pc_plus4_m2),
        .misalign_m2(misalign_m2), .bus_err_m2(bus_err_m2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_wait = 0;
    bit          m_live = 1'b0;
    logic        e_rw = 1'b0, e_mis = 1'b0, e_berr = 1'b0;
    logic [1:0]  e_src = 2'b00;
    logic [31:0] e_alu = 32'h0, e_rdata = 32'h0, e_pc = 32'h0;
    logic [4:0]  e_rd = 5'd0;

    function automatic int f_size();
        if (funct3_m1[1:0] == 2'b00) return 1;
        if (funct3_m1[1:0] == 2'b01) return 2;
        return 4;
    endfunction
    function automatic bit f_access();
        return mem_write_m1 || (result_src_m1 == 2'b01);
    endfunction
    function automatic bit f_aligned();
        return (alu_result_m1 % f_size()) == 0;
    endfunction
    function automatic bit f_req();
        return f_access() && f_aligned() && !rst;
    endfunction
    function automatic bit f_tmo();
        return f_req() && (m_wait == TIMEOUT - 1);
    endfunction
    function automatic bit f_stall();
        return f_req() && !dmem_ack && !f_tmo();
    endfunction
    function automatic logic [31:0] f_be();
        int off = alu_result_m1 % 4;
        if (f_size() == 1) return 32'(1 << off);
        if (f_size() == 2) return 32'(3 << off);
        return 32'hF;
    endfunction
    function automatic logic [31:0] f_wdata();
        if (f_size() == 1) return (write_data_m1 % 256) * 32'h0101_0101;
        if (f_size() == 2) return (write_data_m1 % 65536) * 32'h0001_0001;
        return write_data_m1;
    endfunction
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3);
        logic [31:0] b, h;
        b = (word >> (8 * (addr % 4))) % 256;
        h = (word >> (8 * (addr % 4))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // model update on each active edge
    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst || f_stall()) begin
            m_wait  <= rst ? 0 : m_wait + 1;
            e_rw    <= 1'b0; e_src <= 2'b00; e_alu <= 32'h0; e_rdata <= 32'h0;
            e_rd    <= 5'd0; e_pc  <= 32'h0; e_mis <= 1'b0;  e_berr  <= 1'b0;
        end else begin
            m_wait  <= 0;
            e_rw    <= reg_write_m1 && !(f_access() && !f_aligned()) && !(f_tmo() && !dmem_ack);
            e_src   <= result_src_m1;
            e_alu   <= alu_result_m1;
            e_rd    <= rd_m1;
            e_pc    <= pc_plus4_m1;
            e_mis   <= f_access() && !f_aligned();
            e_berr  <= f_tmo() && !dmem_ack;
            e_rdata <= (result_src_m1 == 2'b01 && f_req() && dmem_ack)
                       ? f_extract(dmem_rdata, alu_result_m1, funct3_m1) : 32'h0;
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("req",   32'(dmem_req), 32'(f_req()));
            chk("stall", 32'(stall_m1), 32'(f_stall()));
            chk("we",    32'(dmem_we),  32'(mem_write_m1));
            if (f_req()) chk("addr", dmem_addr, alu_result_m1 - (alu_result_m1 % 4));
            if (f_req() && mem_write_m1) begin
                chk("be",    32'(dmem_be), f_be());
                chk("wdata", dmem_wdata,   f_wdata());
            end
            chk("m2_rw",    32'(reg_write_m2),  32'(e_rw));
            chk("m2_src",   32'(result_src_m2), 32'(e_src));
            chk("m2_alu",   alu_result_m2,      e_alu);
            chk("m2_rdata", read_data_m2,       e_rdata);
            chk("m2_rd",    32'(rd_m2),         32'(e_rd));
            chk("m2_pc",    pc_plus4_m2,        e_pc);
            chk("m2_mis",   32'(misalign_m2),   32'(e_mis));
            chk("m2_berr",  32'(bus_err_m2),    32'(e_berr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic rw, input logic [1:0] src, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, input logic [4:0] rd);
        reg_write_m1 = rw; result_src_m1 = src; mem_write_m1 = we; alu_result_m1 = addr;
        write_data_m1 = wd; funct3_m1 = f3; rd_m1 = rd; pc_plus4_m1 = 32'h1000 + 32'(rd) * 4;
    endtask
    task automatic nop();
        put(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
    endtask
    task automatic step();
        @(posedge clk); #1;
    endtask

    localparam int NV = 9;
    logic [1:0]  v_src [NV] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    logic        v_we  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        v_rw  [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] v_addr[NV] = '{32'h300, 32'h301, 32'h302, 32'h302, 32'h304, 32'h401, 32'h404, 32'h77, 32'h303};
    logic [2:0]  v_f3  [NV] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b000, 3'b010, 3'b000, 3'b001};
    logic [31:0] v_wd  [NV] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5655, 32'h89AB_CDEF, 32'h0, 32'h0};
    logic [31:0] v_rdat[NV] = '{32'h0000_007F, 32'h0000_9A00, 32'h8001_7FFF, 32'h8001_7FFF, 32'hCAFE_F00D,
                                32'h0, 32'h0, 32'h5555_5555, 32'hFFFF_FFFF};
    logic [31:0] v_exrd[NV] = '{32'h7F, 32'h9A, 32'hFFFF_8001, 32'h0000_8001, 32'hCAFE_F00D,
                                32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  v_exbe[NV] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b1111, 4'h0, 4'h0};

    int stalls, bubbles;

    initial begin
        nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
        step(); step();
        @(negedge clk);
        chk("rst_rw", 32'(reg_write_m2), 32'h0);
        chk("rst_flags", {30'h0, misalign_m2, bus_err_m2}, 32'h0);
        step(); rst = 1'b0;

        // LW with same-cycle ack
        put(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 3'b010, 5'd3); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("lw_nostall", 32'(stall_m1), 32'h0);
        step(); nop(); dmem_ack = 1'b0;
        @(negedge clk); chk("lw_data", read_data_m2, 32'hDEAD_BEEF); chk("lw_rw", 32'(reg_write_m2), 32'h1);

        // LB 0x103 acked after 3 wait cycles
        step(); put(1'b1, 2'b01, 1'b0, 32'h103, 32'h0, 3'b000, 5'd5); dmem_rdata = 32'h80FF_0000;
        stalls = 0; bubbles = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stalls += int'(stall_m1);
            if (i > 0 && !reg_write_m2 && rd_m2 == 5'd0) bubbles++;
            step();
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        if (!reg_write_m2 && rd_m2 == 5'd0) bubbles++;
        chk("lb_stalls", 32'(stalls), 32'd3);
        chk("lb_bubbles", 32'(bubbles), 32'd3);
        step(); nop(); dmem_ack = 1'b0;
        @(negedge clk); chk("lb_data", read_data_m2, 32'hFFFF_FF80);

        // SH 0x202
        step(); put(1'b0, 2'b00, 1'b1, 32'h202, 32'h1234_ABCD, 3'b001, 5'd0); dmem_ack = 1'b1;
        @(negedge clk);
        chk("sh_be", 32'(dmem_be), 32'hC); chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(dmem_we), 32'h1);

        // misaligned LW
        step(); put(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 3'b010, 5'd7); dmem_ack = 1'b0;
        @(negedge clk); chk("mis_req", 32'(dmem_req), 32'h0);
        step(); nop();
        @(negedge clk); chk("mis_flag", 32'(misalign_m2), 32'h1); chk("mis_rw", 32'(reg_write_m2), 32'h0);
        step();
        @(negedge clk); chk("mis_once", 32'(misalign_m2), 32'h0);

        // timeout, bounded wait
        step(); put(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, 3'b010, 5'd9);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_m1) break;
            stalls++;
            step();
        end
        chk("tmo_stalls", 32'(stalls), 32'd15);
        step(); nop();
        @(negedge clk);
        chk("tmo_berr", 32'(bus_err_m2), 32'h1); chk("tmo_rw", 32'(reg_write_m2), 32'h0);
        chk("tmo_rdata", read_data_m2, 32'h0);
        step();
        @(negedge clk); chk("tmo_once", 32'(bus_err_m2), 32'h0);

        // reset in the second wait cycle
        step(); put(1'b1, 2'b01, 1'b0, 32'h80, 32'h0, 3'b010, 5'd11);
        step(); step(); rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        step(); rst = 1'b0; nop(); dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstw_req", 32'(dmem_req), 32'h0); chk("rstw_rw", 32'(reg_write_m2), 32'h0);
        chk("rstw_rdata", read_data_m2, 32'h0); chk("rstw_rd", 32'(rd_m2), 32'h0);
        chk("rstw_pc", pc_plus4_m2, 32'h0);

        // assorted single-cycle vectors
        for (int k = 0; k < NV; k++) begin
            step();
            put(v_rw[k], v_src[k], v_we[k], v_addr[k], v_wd[k], v_f3[k], 5'(k + 12));
            dmem_ack = 1'b1; dmem_rdata = v_rdat[k];
            @(negedge clk);
            if (v_we[k]) chk("vec_be", 32'(dmem_be), 32'(v_exbe[k]));
            step(); nop(); dmem_ack = 1'b0;
            @(negedge clk); chk("vec_rdata", read_data_m2, v_exrd[k]);
        end

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
